// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU control codes and datapath width
package alu_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by both arbiter ports
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] SourceA,
    input  logic [DATA_W-1:0] SourceB,
    input  logic [2:0]        aluCtrl,
    output logic [DATA_W-1:0] ALUResult
);

    // Decode the control code; unknown codes give zero, arithmetic wraps
    always_comb begin
        ALUResult = '0;
        case (aluCtrl)
            CTRL_AND: ALUResult = SourceA & SourceB;
            CTRL_OR:  ALUResult = SourceA | SourceB;
            CTRL_ADD: ALUResult = SourceA + SourceB;
            CTRL_SUB: ALUResult = SourceA - SourceB;
            default:  ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one ALU with registered responses
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result
);

    logic              ptr_q, ptr_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;

    logic              elig0, elig1, grant0, grant1;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]        alu_ctrl;

    // Grant decision: a port may win only if its response slot is free or draining now
    always_comb begin
        elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
        // Port 1 wins a tie only in round-robin mode with the pointer on it
        grant0 = !reset && elig0 && !(elig1 && RR_EN && ptr_q);
        grant1 = !reset && elig1 && !grant0;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux feeding the single shared ALU
    always_comb begin
        alu_a    = grant1 ? req1_a    : req0_a;
        alu_b    = grant1 ? req1_b    : req0_b;
        alu_ctrl = grant1 ? req1_ctrl : req0_ctrl;
    end

    alu_arbiter_alu u_alu (
        .SourceA   (alu_a),
        .SourceB   (alu_b),
        .aluCtrl   (alu_ctrl),
        .ALUResult (alu_result)
    );

    // Next state: a grant refills the slot, a drain without grant empties it
    always_comb begin
        rsp0_valid_d  = grant0 || (rsp0_valid_q && !rsp0_ready);
        rsp1_valid_d  = grant1 || (rsp1_valid_q && !rsp1_ready);
        rsp0_result_d = grant0 ? alu_result : rsp0_result_q;
        rsp1_result_d = grant1 ? alu_result : rsp1_result_q;
        ptr_d         = ptr_q;
        if (RR_EN && grant0) begin
            ptr_d = 1'b1;
        end else if (RR_EN && grant1) begin
            ptr_d = 1'b0;
        end
    end

    // State registers; reset drops any held or just-accepted result
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for round-robin and fixed-priority arbiters
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_v;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [2:0]  req_c [2];
    logic [1:0]  rsp_rdy;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [1:0]  rdy [2];
    logic [1:0]  rv  [2];
    logic [31:0] res [2][2];

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req_v[0]), .req0_ready(rdy[0][0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_ctrl(req_c[0]),
        .rsp0_valid(rv[0][0]), .rsp0_ready(rsp_rdy[0]), .rsp0_result(res[0][0]),
        .req1_valid(req_v[1]), .req1_ready(rdy[0][1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_ctrl(req_c[1]),
        .rsp1_valid(rv[0][1]), .rsp1_ready(rsp_rdy[1]), .rsp1_result(res[0][1])
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req_v[0]), .req0_ready(rdy[1][0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_ctrl(req_c[0]),
        .rsp0_valid(rv[1][0]), .rsp0_ready(rsp_rdy[0]), .rsp0_result(res[1][0]),
        .req1_valid(req_v[1]), .req1_ready(rdy[1][1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_ctrl(req_c[1]),
        .rsp1_valid(rv[1][1]), .rsp1_ready(rsp_rdy[1]), .rsp1_result(res[1][1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: slot occupancy, pointer, expected-result queues
    bit          full [2][2];
    bit          ptr  [2];
    logic [31:0] q00 [$];
    logic [31:0] q01 [$];
    logic [31:0] q10 [$];
    logic [31:0] q11 [$];

    function automatic int qsize(int k);
        case (k)
            0: return q00.size();
            1: return q01.size();
            2: return q10.size();
            default: return q11.size();
        endcase
    endfunction

    function automatic logic [31:0] qfront(int k);
        case (k)
            0: return q00[0];
            1: return q01[0];
            2: return q10[0];
            default: return q11[0];
        endcase
    endfunction

    task automatic qpush(int k, logic [31:0] v);
        case (k)
            0: q00.push_back(v);
            1: q01.push_back(v);
            2: q10.push_back(v);
            default: q11.push_back(v);
        endcase
    endtask

    task automatic qpop(int k, output logic [31:0] v);
        case (k)
            0: v = q00.pop_front();
            1: v = q01.pop_front();
            2: v = q10.pop_front();
            default: v = q11.pop_front();
        endcase
    endtask

    function automatic logic [31:0] ref_alu(logic [31:0] x, logic [31:0] y, logic [2:0] op);
        case (op)
            3'b000: return x & y;
            3'b001: return x | y;
            3'b010: return x + y;
            3'b110: return x - y;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; predicts grants from the rules and pushes expected results
    task automatic cycle(logic rst, logic [1:0] vv,
                         logic [31:0] a0, logic [31:0] b0, logic [2:0] c0,
                         logic [31:0] a1, logic [31:0] b1, logic [2:0] c1,
                         logic [1:0] rr);
        bit g [2][2];
        bit el [2];
        reset    = rst;
        req_v    = vv;
        req_a[0] = a0; req_b[0] = b0; req_c[0] = c0;
        req_a[1] = a1; req_b[1] = b1; req_c[1] = c1;
        rsp_rdy  = rr;
        #1;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) el[p] = vv[p] && (!full[m][p] || rr[p]);
            g[m][0] = 0;
            g[m][1] = 0;
            if (!rst) begin
                if (el[0] && el[1]) begin
                    if (m == 0 && ptr[m]) g[m][1] = 1;
                    else g[m][0] = 1;
                end else if (el[0]) g[m][0] = 1;
                else if (el[1]) g[m][1] = 1;
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("req_ready inst%0d port%0d", m, p), {31'b0, rdy[m][p]}, {31'b0, g[m][p]});
                chk($sformatf("rsp_valid inst%0d port%0d", m, p), {31'b0, rv[m][p]}, {31'b0, full[m][p]});
                if (full[m][p] && qsize(m*2+p) > 0)
                    chk($sformatf("rsp_hold inst%0d port%0d", m, p), res[m][p], qfront(m*2+p));
                if (g[m][p])
                    qpush(m*2+p, ref_alu(req_a[p], req_b[p], req_c[p]));
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                full[m][0] = 0;
                full[m][1] = 0;
                ptr[m] = 0;
            end else begin
                for (int p = 0; p < 2; p++)
                    full[m][p] = g[m][p] ? 1'b1 : (rr[p] ? 1'b0 : full[m][p]);
                if (m == 0 && (g[m][0] || g[m][1])) ptr[m] = g[m][0];
            end
        end
        if (rst) begin
            q00.delete(); q01.delete(); q10.delete(); q11.delete();
        end
    endtask

    // Monitor: every completed response handshake must match the oldest expected result
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (rv[m][p] === 1'b1 && rsp_rdy[p] === 1'b1) begin
                        automatic int k = m*2 + p;
                        automatic logic [31:0] e;
                        if (qsize(k) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_unexpected inst%0d port%0d at %0t: actual %h expected none", m, p, $time, res[m][p]);
                        end else begin
                            qpop(k, e);
                            chk($sformatf("rsp_result inst%0d port%0d", m, p), res[m][p], e);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rnd32();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] rnd_ctrl();
        case ($urandom_range(5))
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b110;
            default: return 3'($urandom_range(7));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req_v = 2'b00;
        rsp_rdy = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_a[p] = '0; req_b[p] = '0; req_c[p] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        cycle(1, 2'b11, 1, 2, 3'b010, 3, 4, 3'b010, 2'b11);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                chk($sformatf("reset_result inst%0d port%0d", m, p), res[m][p], 32'h0);

        // 5+3 on port 0 with the consumer ready
        cycle(0, 2'b01, 5, 3, 3'b010, 0, 0, 3'b000, 2'b11);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);

        // Both ports requesting every cycle: wrap-around add and subtract
        repeat (4) cycle(0, 2'b11, 32'hFFFF_FFFF, 1, 3'b010, 0, 1, 3'b110, 2'b11);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);

        // Port 1 backpressure: held result, blocked request, then accept on release
        cycle(0, 2'b10, 0, 0, 3'b000, 32'h00F0, 0, 3'b001, 2'b00);
        repeat (3) cycle(0, 2'b10, 0, 0, 3'b000, 32'h0FF0, 32'hF0F0, 3'b000, 2'b00);
        cycle(0, 2'b10, 0, 0, 3'b000, 32'h0FF0, 32'hF0F0, 3'b000, 2'b10);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);

        // Undefined ctrl, then reset while the result is held; port 0 preferred afterwards
        cycle(0, 2'b01, 7, 9, 3'b111, 0, 0, 3'b000, 2'b00);
        cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b00);
        cycle(1, 2'b11, 1, 1, 3'b010, 2, 2, 3'b010, 2'b00);
        cycle(0, 2'b11, 1, 1, 3'b010, 2, 2, 3'b010, 2'b11);
        cycle(0, 2'b11, 6, 3, 3'b110, 6, 3, 3'b001, 2'b11);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(99) == 0,
                  {1'($urandom_range(9) < 7), 1'($urandom_range(9) < 7)},
                  rnd32(), rnd32(), rnd_ctrl(),
                  rnd32(), rnd32(), rnd_ctrl(),
                  {1'($urandom_range(9) < 6), 1'($urandom_range(9) < 6)});
        end

        repeat (4) cycle(0, 2'b00, 0, 0, 3'b000, 0, 0, 3'b000, 2'b11);
        for (int k = 0; k < 4; k++)
            chk($sformatf("drain_empty queue%0d", k), qsize(k), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority to port 0.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  port 0 operation request.
REQ-005 req0_ready  out  1  port 0 request accepted this cycle.
REQ-006 req0_a, req0_b  in  32 each  port 0 operands (SourceA, SourceB).
REQ-007 req0_ctrl  in  3  port 0 ALU control: 000 and, 001 or, 010 add, 110 sub.
REQ-008 rsp0_valid  out  1  port 0 result held.
REQ-009 rsp0_ready  in  1  port 0 consumer accepts the result.
REQ-010 rsp0_result  out  32  port 0 registered ALU result.
REQ-011 req1_*, rsp1_* SHALL be identical to the port 0 signals, for port 1.

Function
REQ-012 The block SHALL share one combinational ALU between ports 0 and 1, with at most one grant per cycle.
REQ-013 Port i is eligible when reqi_valid=1 and its response slot is free: rspi_valid=0, or rspi_valid=1 and rspi_ready=1 in the same cycle.
REQ-014 reqi_ready SHALL be 1 only in a cycle where port i is granted; it is combinational from valid, slot state and pointer.
REQ-015 Only one port eligible: that port is granted.
REQ-016 Both ports eligible, RR_EN=1: the port named by the 1-bit priority pointer is granted. RR_EN=0: port 0 is granted.
REQ-017 After any grant with RR_EN=1, the pointer SHALL move to the non-granted port. With no grant, the pointer holds.
REQ-018 On a grant, the ALU result of the granted operands and ctrl SHALL be captured into rspi_result, with rspi_valid=1 on the next cycle. Latency is 1 cycle from accept to valid.
REQ-019 ALU semantics: and, or, 32-bit add, 32-bit sub, each wrapping modulo 2^32 with no overflow flag. Any other ctrl code yields 32'h0.
REQ-020 rspi_valid and rspi_result SHALL hold stable while rspi_ready=0.
REQ-021 rspi_valid=1 with rspi_ready=1 and no new grant to port i: rspi_valid clears next cycle.
REQ-022 Same cycle drain and grant on port i: rspi_valid stays 1 and rspi_result takes the new value (back-to-back throughput).
REQ-023 A non-granted valid request SHALL be held by its requester. The block does not latch operands before the grant.
REQ-024 With RR_EN=1 and both ports continuously eligible, grants SHALL strictly alternate, so neither port waits more than 1 cycle.

Reset
REQ-025 While reset=1 at a clock edge: rsp0_valid=rsp1_valid=0, rsp0_result=rsp1_result=32'h0, and pointer=0 (port 0 preferred).
REQ-026 reqi_ready SHALL be 0 in any cycle where reset=1.
REQ-027 Reset asserted mid-operation SHALL discard any held or just-accepted result. No response appears after reset releases.

Structure
REQ-028 A shared package SHALL hold the ALU control constants (AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110) and the 32-bit data width constant.
REQ-029 The ALU datapath SHALL be a single instance of the team's existing ALU sub-module (ports SourceA, SourceB, aluCtrl, ALUResult), fed through the grant mux.
REQ-030 The arbiter, pointer and response registers SHALL live in alu_arbiter. No other sub-modules.

Verification
REQ-031 Reset, then req0 (a=5, b=3, ctrl=010) with rsp0_ready=1: req0_ready=1 in cycle 0; rsp0_valid=1 and rsp0_result=8 in cycle 1; rsp0_valid=0 in cycle 2.
REQ-032 Both ports request every cycle with RR_EN=1 and both rsp_ready=1: grant order is 0,1,0,1. Operands port0 (32'hFFFFFFFF+1, add) gives 0; port1 (0-1, sub) gives 32'hFFFFFFFF.
REQ-033 Backpressure: rsp1_ready=0 with a held result of 32'h00F0 (and of 32'h0FF0 with 32'hF0F0). A new req1 is not granted and the result stays stable. Raising rsp1_ready accepts the new request in that cycle, and the next result appears 1 cycle later.
REQ-034 RR_EN=0 with both ports continuously valid and ready: port 1 is never granted while port 0 stays eligible.
REQ-035 ctrl=3'b111 with a=7, b=9 gives result 0. Reset asserted while rsp0_valid=1 gives rsp0_valid=0 next cycle and the pointer returns to 0.
